// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: drives a single-bit registered shift unit once per bit,
// feeding each result back as the next operand, and returns the final value via valid/ready.
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [AMT_W-1:0] cmd_amt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy,
   output logic [WIDTH-1:0] shift_a,
   output logic [WIDTH-1:0] shift_b,
   output logic [1:0]       shift_func,
   output logic             shift_en,
   input  logic [WIDTH-1:0] shift_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   work;
   logic [AMT_W-1:0]   cnt;
   logic               dir;

   // Amounts of zero or at least WIDTH resolve at acceptance without using the unit.
   logic amt_zero, amt_big;
   assign amt_zero = (cmd_amt == '0);
   assign amt_big  = (cmd_amt >= AMT_W'(WIDTH));

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               if (amt_zero || amt_big) state_nxt = DONE;
               else                     state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (cnt == AMT_W'(1)) state_nxt = DONE;
            else                  state_nxt = ISSUE;
         end
         DONE: begin
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work <= '0;
         cnt  <= '0;
         dir  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  dir  <= cmd_dir;
                  cnt  <= cmd_amt;
                  work <= amt_big ? '0 : cmd_data;
               end
            end
            WAIT: begin
               work <= shift_out;
               cnt  <= cnt - AMT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign res_valid  = (state == DONE);
   assign res_data   = (state == DONE) ? work : '0;
   assign shift_en   = (state == ISSUE);
   assign shift_a    = work;
   assign shift_b    = '0;
   assign shift_func = {1'b0, dir};

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the registered shift unit.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b0;
   logic [15:0] cmd_data = '0;
   logic [4:0]  cmd_amt = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic        busy;
   logic [15:0] shift_a;
   logic [15:0] shift_b;
   logic [1:0]  shift_func;
   logic        shift_en;
   logic [15:0] shift_out = '0;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int en_total = 0;
   int b_bad = 0;
   int func_bad = 0;
   logic [1:0] last_func = 2'b00;

   shift_sequencer #(.WIDTH(16), .AMT_W(5)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_data(cmd_data), .cmd_amt(cmd_amt),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .shift_a(shift_a), .shift_b(shift_b),
      .shift_func(shift_func), .shift_en(shift_en), .shift_out(shift_out)
   );

   always #5 clk = ~clk;

   // Single-bit registered shift unit and activity monitors.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (shift_b !== 16'h0000) b_bad <= b_bad + 1;
      if (shift_func[1] !== 1'b0) func_bad <= func_bad + 1;
      if (shift_en) begin
         en_total  <= en_total + 1;
         last_func <= shift_func;
         shift_out <= shift_func[0] ? (shift_a << 1) : (shift_a >> 1);
      end
   end

   task automatic send(input logic d, input logic [15:0] data, input logic [4:0] amt,
                       output bit ok);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = d; cmd_data = data; cmd_amt = amt;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (cmd_ready) begin
            @(posedge clk); #1;
            acc_cyc = cyc;
            ok = 1'b1;
            // Scramble inputs after acceptance; they must not affect the result.
            cmd_valid = 1'b0; cmd_dir = ~d; cmd_data = ~data; cmd_amt = 5'd3;
            break;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic get_result(output logic [15:0] data, output int lat, output bit ok);
      ok = 1'b0; data = '0; lat = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (res_valid) begin
            data = res_data; lat = cyc - acc_cyc; ok = 1'b1;
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({cmd_ready, res_valid, busy, shift_en} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got rdy/val/busy/en=%b want 1000", {cmd_ready, res_valid, busy, shift_en});
      end
      tests_run++;
      if ({res_data, shift_a, shift_func} !== 34'h0) begin
         tests_failed++;
         $display("FAIL reset_data: res_data=%h shift_a=%h func=%b want 0", res_data, shift_a, shift_func);
      end
      rst = 1'b0;
   endtask

   task automatic test_shift(input string name, input logic d, input logic [15:0] data,
                             input logic [4:0] amt, input logic [15:0] exp,
                             input int exp_lat, input int exp_en);
      logic [15:0] got; int lat; bit ok_s, ok_r; int en0;
      en0 = en_total;
      send(d, data, amt, ok_s);
      get_result(got, lat, ok_r);
      tests_run++;
      if (!(ok_s && ok_r) || got !== exp) begin
         tests_failed++;
         $display("FAIL %s_data: got %h (acc=%0d res=%0d) want %h", name, got, ok_s, ok_r, exp);
      end
      tests_run++;
      if (lat !== exp_lat) begin
         tests_failed++;
         $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
      end
      tests_run++;
      if (en_total - en0 !== exp_en) begin
         tests_failed++;
         $display("FAIL %s_en_count: got %0d want %0d", name, en_total - en0, exp_en);
      end
      if (exp_en > 0) begin
         tests_run++;
         if (last_func !== {1'b0, d}) begin
            tests_failed++;
            $display("FAIL %s_func: got %b want %b", name, last_func, {1'b0, d});
         end
      end
   endtask

   task automatic test_shift_b;
      tests_run++;
      if (b_bad !== 0 || func_bad !== 0) begin
         tests_failed++;
         $display("FAIL shift_b_func: nonzero shift_b cycles %0d, func 1x cycles %0d want 0/0", b_bad, func_bad);
      end
   endtask

   task automatic test_backpressure;
      bit ok; logic [15:0] got; int lat; int en0; bit stable_bad;
      send(1'b1, 16'h00F0, 5'd3, ok);     // expected 16'h0780
      for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
      // Present a new command while the result is held back.
      cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_data = 16'h8000; cmd_amt = 5'd2;
      en0 = en_total; stable_bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_data !== 16'h0780 || cmd_ready !== 1'b0) stable_bad = 1'b1;
      end
      tests_run++;
      if (stable_bad || en_total != en0) begin
         tests_failed++;
         $display("FAIL bp_hold: res_data=%h valid=%b cmd_ready=%b en_delta=%0d want 0780/1/0/0",
                  res_data, res_valid, cmd_ready, en_total - en0);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_handoff: cmd_ready=%b res_valid=%b want 1/0", cmd_ready, res_valid);
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      cmd_valid = 1'b0;
      get_result(got, lat, ok);
      tests_run++;
      if (!ok || got !== 16'h2000 || lat !== 4) begin
         tests_failed++;
         $display("FAIL bp_pending: got %h lat %0d want 2000 lat 4", got, lat);
      end
   endtask

   task automatic test_reset_mid;
      bit ok; logic [15:0] got; int lat;
      send(1'b0, 16'hFFFF, 5'd6, ok);
      @(posedge clk); @(posedge clk); @(posedge clk); // after e3: in WAIT
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid: valid=%b busy=%b cmd_ready=%b want 0/0/1", res_valid, busy, cmd_ready);
      end
      test_shift("after_reset", 1'b1, 16'h0003, 5'd2, 16'h000C, 4, 2);
   endtask

   typedef struct {
      logic        d;
      logic [15:0] data;
      logic [4:0]  amt;
      logic [15:0] exp;
   } vec_t;

   task automatic test_back_to_back;
      vec_t v[8];
      v[0] = '{1'b1, 16'h1234, 5'd4,  16'h2340};
      v[1] = '{1'b0, 16'h8001, 5'd1,  16'h4000};
      v[2] = '{1'b0, 16'hFFFF, 5'd15, 16'h0001};
      v[3] = '{1'b1, 16'hA5A5, 5'd8,  16'hA500};
      v[4] = '{1'b0, 16'hA5A5, 5'd16, 16'h0000};
      v[5] = '{1'b1, 16'h00FF, 5'd0,  16'h00FF};
      v[6] = '{1'b0, 16'h1234, 5'd31, 16'h0000};
      v[7] = '{1'b0, 16'hC000, 5'd14, 16'h0003};
      foreach (v[i]) begin
         int n;
         n = (v[i].amt < 5'd16) ? int'(v[i].amt) : 0;
         test_shift($sformatf("b2b%0d", i), v[i].d, v[i].data, v[i].amt, v[i].exp, 2 * n, n);
      end
   endtask

   initial begin
      test_reset;
      test_shift("right4", 1'b0, 16'hF00F, 5'd4, 16'h0F00, 8, 4);
      test_shift("left15", 1'b1, 16'h0001, 5'd15, 16'h8000, 30, 15);
      test_shift_b;
      test_shift("amt0", 1'b0, 16'hABCD, 5'd0, 16'hABCD, 0, 0);
      test_shift("amt16", 1'b1, 16'hFFFF, 5'd16, 16'h0000, 0, 0);
      test_shift("amt31", 1'b0, 16'hFFFF, 5'd31, 16'h0000, 0, 0);
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      test_shift_b;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
